// File: rtl/stack_alu_sequencer.sv
// Postfix program sequencer for a stack-based ALU. It stores host tokens, issues one token
// every two cycles, checks each ALU response, then pops the final result for the host.
module stack_alu_sequencer #(
   parameter int unsigned N          = 4,
   parameter int unsigned PROG_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load_valid,
   input  logic [N+2:0]                  load_token,
   output logic                          load_ready,
   input  logic                          prog_clear,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [$clog2(PROG_DEPTH)-1:0] err_pc,
   output logic signed [N-1:0]           result,
   output logic                          result_ovf,
   output logic [2:0]                    alu_opcode,
   output logic [N-1:0]                  alu_input_data,
   input  logic signed [N-1:0]           alu_output_data,
   input  logic                          alu_overflow,
   input  logic                          alu_success
);

   localparam int unsigned PW = $clog2(PROG_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = N + 3;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PUSH = 3'b110;
   localparam logic [2:0] OP_POP  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CHECK,
      S_FINAL_POP,
      S_FINAL_CHECK,
      S_DONE
   } state_t;

   state_t               state, state_n;
   logic [TW-1:0]        mem [PROG_DEPTH];
   logic [CW-1:0]        count, count_n;
   logic [PW-1:0]        pc, pc_n;
   logic                 error_n, ovf_n, busy_n, done_n, ready_n;
   logic [PW-1:0]        err_pc_n;
   logic signed [N-1:0]  result_n;
   logic [2:0]           opcode_n;
   logic [N-1:0]         data_n;
   logic [2:0]           cur_op;
   logic [2:0]           nxt_op;
   logic [N-1:0]         nxt_operand;
   logic                 load_fire;

   function automatic logic op_valid(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_MUL) || (op == OP_PUSH) || (op == OP_POP);
   endfunction

   // prog_clear wins over a simultaneous load
   assign load_fire = load_valid && load_ready && !prog_clear;
   assign cur_op    = mem[pc][TW-1 -: 3];
   assign {nxt_op, nxt_operand} = mem[pc_n];

   // Program memory is intentionally not reset so a program survives between runs
   always_ff @(posedge clk) begin
      if (load_fire) begin
         mem[count[PW-1:0]] <= load_token;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         count          <= '0;
         pc             <= '0;
         error          <= 1'b0;
         err_pc         <= '0;
         result         <= '0;
         result_ovf     <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         load_ready     <= 1'b1;
         alu_opcode     <= OP_NOP;
         alu_input_data <= '0;
      end else begin
         state          <= state_n;
         count          <= count_n;
         pc             <= pc_n;
         error          <= error_n;
         err_pc         <= err_pc_n;
         result         <= result_n;
         result_ovf     <= ovf_n;
         busy           <= busy_n;
         done           <= done_n;
         load_ready     <= ready_n;
         alu_opcode     <= opcode_n;
         alu_input_data <= data_n;
      end
   end

   // Next-state and status
   always_comb begin
      state_n  = state;
      count_n  = count;
      pc_n     = pc;
      error_n  = error;
      err_pc_n = err_pc;
      result_n = result;
      ovf_n    = result_ovf;
      case (state)
         S_IDLE: begin
            if (prog_clear) begin
               count_n = '0;
            end else if (load_fire) begin
               count_n = count + CW'(1);
            end
            if (start) begin
               error_n = 1'b0;
               ovf_n   = 1'b0;
               pc_n    = '0;
               if (count_n == '0) begin
                  error_n  = 1'b1;
                  err_pc_n = '0;
                  state_n  = S_DONE;
               end else begin
                  state_n = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (!op_valid(cur_op)) begin
               error_n  = 1'b1;
               err_pc_n = pc;
               state_n  = S_DONE;
            end else begin
               state_n = S_CHECK;
            end
         end
         S_CHECK: begin
            if (!alu_success) begin
               error_n  = 1'b1;
               err_pc_n = pc;
               state_n  = S_DONE;
            end else begin
               if ((cur_op == OP_ADD) || (cur_op == OP_MUL)) begin
                  ovf_n = result_ovf | alu_overflow;
               end
               if (CW'(pc) == count - CW'(1)) begin
                  state_n = S_FINAL_POP;
               end else begin
                  pc_n    = pc + PW'(1);
                  state_n = S_ISSUE;
               end
            end
         end
         S_FINAL_POP: begin
            state_n = S_FINAL_CHECK;
         end
         S_FINAL_CHECK: begin
            if (alu_success) begin
               result_n = alu_output_data;
            end else begin
               error_n  = 1'b1;
               err_pc_n = PW'(PROG_DEPTH - 1);
            end
            state_n = S_DONE;
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Registered outputs follow the state being entered; invalid tokens go out as NOP
   always_comb begin
      opcode_n = OP_NOP;
      data_n   = '0;
      busy_n   = (state_n == S_ISSUE) || (state_n == S_CHECK) ||
                 (state_n == S_FINAL_POP) || (state_n == S_FINAL_CHECK);
      done_n   = (state_n == S_DONE);
      ready_n  = (state_n == S_IDLE) && (count_n < CW'(PROG_DEPTH));
      if ((state_n == S_ISSUE) && op_valid(nxt_op)) begin
         opcode_n = nxt_op;
         if (nxt_op == OP_PUSH) begin
            data_n = nxt_operand;
         end
      end else if (state_n == S_FINAL_POP) begin
         opcode_n = OP_POP;
      end
   end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: a behavioural stack ALU answers the sequencer, and a
// token-level program model predicts result, flags, latency and the opcode trace.
module tb_stack_alu_sequencer;

   localparam int N         = 4;
   localparam int PD        = 16;
   localparam int PW        = 4;
   localparam int ALU_DEPTH = 8;
   localparam int MAXV      = (1 << (N - 1)) - 1;
   localparam int MINV      = -(1 << (N - 1));

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PUSH = 3'b110;
   localparam logic [2:0] OP_POP  = 3'b111;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                load_valid = 1'b0;
   logic [N+2:0]        load_token = '0;
   logic                load_ready;
   logic                prog_clear = 1'b0;
   logic                start = 1'b0;
   logic                busy, done, error, result_ovf;
   logic [PW-1:0]       err_pc;
   logic signed [N-1:0] result;
   logic [2:0]          alu_opcode;
   logic [N-1:0]        alu_input_data;
   logic signed [N-1:0] alu_out = '0;
   logic                alu_ovf = 1'b0;
   logic                alu_ok = 1'b0;

   int checks = 0;
   int failures = 0;
   int bad_op_cnt = 0;

   logic [N+2:0] prog[$];
   int alu_stk[$];
   int model_stk[$];
   int exp_trace[$];
   int obs_trace[$];
   int exp_result = 0;
   int exp_err, exp_errpc, exp_ovf, exp_lat;
   int obs_lat, obs_busy_bad, obs_done2;

   stack_alu_sequencer #(.N(N), .PROG_DEPTH(PD)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_token(load_token), .load_ready(load_ready),
      .prog_clear(prog_clear), .start(start),
      .busy(busy), .done(done), .error(error), .err_pc(err_pc),
      .result(result), .result_ovf(result_ovf),
      .alu_opcode(alu_opcode), .alu_input_data(alu_input_data),
      .alu_output_data(alu_out), .alu_overflow(alu_ovf), .alu_success(alu_ok)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int wrap(input int x);
      logic signed [N-1:0] t;
      t = x[N-1:0];
      return int'(t);
   endfunction

   function automatic int alu_raw(input logic [2:0] op, input int a, input int b);
      return (op == OP_MUL) ? a * b : a + b;
   endfunction

   function automatic string tstr(input int q[$]);
      string s = "";
      foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
      return s;
   endfunction

   function automatic logic [N+2:0] tok(input logic [2:0] op, input int v);
      return {op, v[N-1:0]};
   endfunction

   // Stack ALU: outputs registered on the edge at which the opcode is presented
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_stk.delete();
         alu_out <= '0;
         alu_ovf <= 1'b0;
         alu_ok  <= 1'b0;
      end else begin
         case (alu_opcode)
            OP_PUSH: begin
               alu_ovf <= 1'b0;
               if (alu_stk.size() < ALU_DEPTH) begin
                  alu_stk.push_back(int'($signed(alu_input_data)));
                  alu_out <= alu_input_data;
                  alu_ok  <= 1'b1;
               end else alu_ok <= 1'b0;
            end
            OP_POP: begin
               alu_ovf <= 1'b0;
               if (alu_stk.size() > 0) begin
                  alu_out <= N'(alu_stk.pop_back());
                  alu_ok  <= 1'b1;
               end else alu_ok <= 1'b0;
            end
            OP_ADD, OP_MUL: begin
               if (alu_stk.size() >= 2) begin
                  alu_out <= N'(alu_raw(alu_opcode, alu_stk[$], alu_stk[$-1]));
                  alu_ovf <= (alu_raw(alu_opcode, alu_stk[$], alu_stk[$-1]) > MAXV) ||
                             (alu_raw(alu_opcode, alu_stk[$], alu_stk[$-1]) < MINV);
                  alu_ok  <= 1'b1;
                  alu_stk.push_back(wrap(alu_raw(alu_opcode, alu_stk[$], alu_stk[$-1])));
                  alu_stk.delete(alu_stk.size() - 2);
                  alu_stk.delete(alu_stk.size() - 2);
               end else begin
                  alu_ok  <= 1'b0;
                  alu_ovf <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst && !(alu_opcode inside {OP_NOP, OP_ADD, OP_MUL, OP_PUSH, OP_POP}))
         bad_op_cnt++;
   end

   // Token-level prediction of one run over the first n program entries
   task automatic model_run(input int n);
      int a, b, raw, opnd;
      bit ok;
      logic [N+2:0] t;
      logic [2:0] op;
      logic signed [N-1:0] sv;
      exp_trace.delete();
      exp_err = 0;
      exp_ovf = 0;
      if (n == 0) begin
         exp_err = 1; exp_errpc = 0; exp_lat = 1;
         return;
      end
      for (int i = 0; i < n; i++) begin
         t = prog[i];
         op = t[N+2:N];
         sv = t[N-1:0];
         opnd = int'(sv);
         if (!(op inside {OP_ADD, OP_MUL, OP_PUSH, OP_POP})) begin
            exp_trace.push_back(0);
            exp_err = 1; exp_errpc = i; exp_lat = 2 * i + 2;
            return;
         end
         exp_trace.push_back(int'(op));
         exp_trace.push_back(0);
         ok = 0;
         case (op)
            OP_PUSH: if (model_stk.size() < ALU_DEPTH) begin
               model_stk.push_back(opnd); ok = 1;
            end
            OP_POP: if (model_stk.size() > 0) begin
               void'(model_stk.pop_back()); ok = 1;
            end
            default: if (model_stk.size() >= 2) begin
               a = model_stk.pop_back();
               b = model_stk.pop_back();
               raw = (op == OP_ADD) ? a + b : a * b;
               if (raw > MAXV || raw < MINV) exp_ovf = 1;
               model_stk.push_back(wrap(raw));
               ok = 1;
            end
         endcase
         if (!ok) begin
            exp_err = 1; exp_errpc = i; exp_lat = 2 * i + 3;
            return;
         end
      end
      exp_trace.push_back(int'(OP_POP));
      exp_trace.push_back(0);
      exp_lat = 2 * n + 3;
      if (model_stk.size() > 0) exp_result = model_stk.pop_back();
      else begin
         exp_err = 1; exp_errpc = PD - 1;
      end
   endtask

   task automatic load_prog(input int n);
      @(negedge clk) prog_clear = 1'b1;
      @(negedge clk) prog_clear = 1'b0;
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_token = prog[i];
         @(negedge clk);
      end
      load_valid = 1'b0;
   endtask

   // Pulses start and records opcode trace, busy behaviour and done latency
   task automatic run_prog();
      int cyc;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 1;
      obs_trace.delete();
      obs_busy_bad = 0;
      while (!done && cyc < 300) begin
         obs_trace.push_back(int'(alu_opcode));
         if (!busy) obs_busy_bad++;
         @(negedge clk);
         cyc++;
      end
      obs_lat = done ? cyc : -1;
      if (busy) obs_busy_bad++;
      @(negedge clk);
      obs_done2 = int'(done);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (alu_opcode !== OP_NOP || alu_input_data !== '0) begin failures++;
         $display("FAIL reset_alu_if: got op=%0d data=%0d expected 0 0", alu_opcode, alu_input_data); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin failures++;
         $display("FAIL reset_flags: got busy=%0b done=%0b error=%0b expected 0 0 0", busy, done, error); end
      checks++; if (result !== '0 || result_ovf !== 1'b0 || err_pc !== '0) begin failures++;
         $display("FAIL reset_result: got result=%0d ovf=%0b err_pc=%0d expected 0 0 0", result, result_ovf, err_pc); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (load_ready !== 1'b1) begin failures++;
         $display("FAIL reset_load_ready: got %0b expected 1", load_ready); end
   endtask

   task automatic test_basic_add();
      prog = '{tok(OP_PUSH, 3), tok(OP_PUSH, 2), tok(OP_ADD, 0)};
      load_prog(3);
      model_run(3);
      run_prog();
      checks++; if (obs_lat != 9) begin failures++;
         $display("FAIL basic_latency: got %0d expected 9", obs_lat); end
      checks++; if (tstr(obs_trace) != "6 0 6 0 4 0 7 0 ") begin failures++;
         $display("FAIL basic_trace: got '%s' expected '6 0 6 0 4 0 7 0 '", tstr(obs_trace)); end
      checks++; if (int'(result) != 5 || result_ovf !== 1'b0 || error !== 1'b0) begin failures++;
         $display("FAIL basic_result: got %0d ovf=%0b err=%0b expected 5 0 0", result, result_ovf, error); end
      checks++; if (obs_busy_bad != 0 || obs_done2 != 0) begin failures++;
         $display("FAIL basic_busy_done: got busy_bad=%0d done_after=%0d expected 0 0", obs_busy_bad, obs_done2); end
   endtask

   task automatic test_overflow();
      prog = '{tok(OP_PUSH, 7), tok(OP_PUSH, 1), tok(OP_ADD, 0)};
      load_prog(3);
      model_run(3);
      run_prog();
      checks++; if (int'(result) != -8 || result_ovf !== 1'b1 || error !== 1'b0) begin failures++;
         $display("FAIL ovf_result: got %0d ovf=%0b err=%0b expected -8 1 0", result, result_ovf, error); end
      checks++; if (obs_lat != 9) begin failures++;
         $display("FAIL ovf_latency: got %0d expected 9", obs_lat); end
   endtask

   task automatic test_mul_rerun();
      prog = '{tok(OP_PUSH, -2), tok(OP_PUSH, 3), tok(OP_MUL, 0)};
      load_prog(3);
      model_run(3);
      run_prog();
      checks++; if (int'(result) != -6 || result_ovf !== 1'b0) begin failures++;
         $display("FAIL mul_result: got %0d ovf=%0b expected -6 0", result, result_ovf); end
      model_run(3);
      run_prog();
      checks++; if (int'(result) != -6 || error !== 1'b0 || obs_lat != 9) begin failures++;
         $display("FAIL mul_rerun: got %0d err=%0b lat=%0d expected -6 0 9", result, error, obs_lat); end
   endtask

   task automatic test_pop_empty();
      prog = '{tok(OP_POP, 0)};
      load_prog(1);
      model_run(1);
      run_prog();
      checks++; if (error !== 1'b1 || err_pc !== 4'd0) begin failures++;
         $display("FAIL pop_empty_err: got err=%0b err_pc=%0d expected 1 0", error, err_pc); end
      checks++; if (int'(result) != -6 || obs_lat != 3) begin failures++;
         $display("FAIL pop_empty_hold: got result=%0d lat=%0d expected -6 3", result, obs_lat); end
      checks++; if (tstr(obs_trace) != tstr(exp_trace) || obs_done2 != 0) begin failures++;
         $display("FAIL pop_empty_trace: got '%s' done_after=%0d expected '%s' 0", tstr(obs_trace), obs_done2, tstr(exp_trace)); end
   endtask

   task automatic test_capacity();
      prog.delete();
      prog.push_back(tok(OP_PUSH, $urandom_range(0, 7)));
      for (int i = 0; i < 7; i++) begin
         prog.push_back(tok(OP_PUSH, $urandom_range(0, 15)));
         prog.push_back(tok(OP_ADD, 0));
      end
      prog.push_back(tok(OP_PUSH, $urandom_range(2, 7)));
      prog.push_back(tok(OP_PUSH, 1));
      load_prog(16);
      checks++; if (load_ready !== 1'b0) begin failures++;
         $display("FAIL cap_ready_full: got %0b expected 0", load_ready); end
      load_valid = 1'b1;
      load_token = prog[16];
      @(negedge clk) load_valid = 1'b0;
      checks++; if (load_ready !== 1'b0) begin failures++;
         $display("FAIL cap_ready_after17: got %0b expected 0", load_ready); end
      model_run(16);
      run_prog();
      checks++; if (obs_lat != 35 || int'(result) != exp_result) begin failures++;
         $display("FAIL cap_run: got lat=%0d result=%0d expected %0d %0d", obs_lat, result, 35, exp_result); end
      checks++; if (int'(result_ovf) != exp_ovf || error !== 1'b0) begin failures++;
         $display("FAIL cap_flags: got ovf=%0b err=%0b expected %0d 0", result_ovf, error, exp_ovf); end
   endtask

   task automatic test_invalid_token();
      bad_op_cnt = 0;
      prog = '{tok(OP_PUSH, 1), tok(OP_PUSH, 2), tok(3'b010, 5), tok(OP_PUSH, 3)};
      load_prog(4);
      model_run(4);
      run_prog();
      checks++; if (error !== 1'b1 || err_pc !== 4'd2 || obs_lat != 6) begin failures++;
         $display("FAIL invalid_err: got err=%0b err_pc=%0d lat=%0d expected 1 2 6", error, err_pc, obs_lat); end
      checks++; if (tstr(obs_trace) != "6 0 6 0 0 " || bad_op_cnt != 0) begin failures++;
         $display("FAIL invalid_trace: got '%s' bad_ops=%0d expected '6 0 6 0 0 ' 0", tstr(obs_trace), bad_op_cnt); end
   endtask

   task automatic test_random();
      int n, r;
      logic [2:0] op;
      for (int it = 0; it < 25; it++) begin
         prog.delete();
         n = $urandom_range(0, 12);
         for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) op = OP_PUSH;
            else if (r < 70) op = OP_ADD;
            else if (r < 88) op = OP_MUL;
            else if (r < 94) op = OP_POP;
            else op = 3'($urandom_range(0, 3));
            prog.push_back(tok(op, $urandom_range(0, 15)));
         end
         load_prog(n);
         model_run(n);
         run_prog();
         checks++; if (obs_lat != exp_lat || tstr(obs_trace) != tstr(exp_trace)) begin failures++;
            $display("FAIL rand%0d_seq: got lat=%0d '%s' expected lat=%0d '%s'", it, obs_lat, tstr(obs_trace), exp_lat, tstr(exp_trace)); end
         checks++; if (int'(error) != exp_err || (exp_err != 0 && int'(err_pc) != exp_errpc)) begin failures++;
            $display("FAIL rand%0d_err: got err=%0b err_pc=%0d expected %0d %0d", it, error, err_pc, exp_err, exp_errpc); end
         checks++; if (int'(result) != exp_result || int'(result_ovf) != exp_ovf) begin failures++;
            $display("FAIL rand%0d_result: got %0d ovf=%0b expected %0d %0d", it, result, result_ovf, exp_result, exp_ovf); end
      end
      checks++; if (bad_op_cnt != 0) begin failures++;
         $display("FAIL rand_bad_opcode: got %0d expected 0", bad_op_cnt); end
   endtask

   task automatic test_reset_midrun();
      int done_seen = 0;
      prog = '{tok(OP_PUSH, 3), tok(OP_PUSH, 2), tok(OP_ADD, 0)};
      load_prog(3);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b1 || alu_opcode !== OP_NOP) begin failures++;
         $display("FAIL midrun_in_check: got busy=%0b op=%0d expected 1 0", busy, alu_opcode); end
      rst = 1'b1;
      #1;
      checks++; if (alu_opcode !== OP_NOP || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin failures++;
         $display("FAIL midrun_reset_now: got op=%0d busy=%0b done=%0b err=%0b expected 0 0 0 0", alu_opcode, busy, done, error); end
      checks++; if (result !== '0 || err_pc !== '0 || result_ovf !== 1'b0) begin failures++;
         $display("FAIL midrun_reset_result: got %0d err_pc=%0d ovf=%0b expected 0 0 0", result, err_pc, result_ovf); end
      model_stk.delete();
      exp_result = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      checks++; if (done_seen != 0) begin failures++;
         $display("FAIL midrun_no_done: got %0d done cycles expected 0", done_seen); end
      model_run(0);
      run_prog();
      checks++; if (error !== 1'b1 || obs_lat != 1) begin failures++;
         $display("FAIL midrun_empty_after_reset: got err=%0b lat=%0d expected 1 1", error, obs_lat); end
      load_prog(3);
      model_run(3);
      run_prog();
      checks++; if (int'(result) != 5 || error !== 1'b0 || obs_lat != 9) begin failures++;
         $display("FAIL midrun_rerun: got %0d err=%0b lat=%0d expected 5 0 9", result, error, obs_lat); end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_overflow();
      test_mul_rerun();
      test_pop_empty();
      test_capacity();
      test_invalid_token();
      test_random();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
